// File: rtl/fsm_sequence_gen.sv
// fsm_sequence_gen: serial pattern transmitter.
//   On an accepted start, shifts a PAT_W-bit pattern MSB first onto o_a and repeats
//   it max(reps,1) times. Consecutive copies are separated by 'gap' idle cycles.
//   All outputs are registered. Reset is synchronous and active-high.
// Ports:
//   i_clk, i_reset     clock, synchronous active-high reset
//   i_start            transmission request, sampled only in IDLE
//   i_pat_in           pattern, latched on accepted start
//   i_reps             copy count, latched on accepted start (0 behaves as 1)
//   i_gap              idle cycles between copies, latched on accepted start
//   i_abort            cancels an active transmission (SEND/GAP)
//   o_a                serial line, IDLE_BIT when no pattern bit is being sent
//   o_a_vld            o_a carries a pattern bit
//   o_busy             accepted start through the DONE cycle
//   o_done             one-cycle pulse after the last bit of the last copy
module fsm_sequence_gen #(
  parameter int unsigned PAT_W    = 4,
  parameter int unsigned REP_W    = 4,
  parameter int unsigned GAP_W    = 4,
  parameter logic        IDLE_BIT = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [PAT_W-1:0] i_pat_in,
  input  logic [REP_W-1:0] i_reps,
  input  logic [GAP_W-1:0] i_gap,
  input  logic             i_abort,
  output logic             o_a,
  output logic             o_a_vld,
  output logic             o_busy,
  output logic             o_done
);

  localparam int unsigned IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic [PAT_W-1:0] r_pat;
  logic [REP_W-1:0] r_copies_left;  // copies still to start after the current one
  logic [GAP_W-1:0] r_gap;
  logic [GAP_W-1:0] r_gap_cnt;      // gap cycles still to go after the current one
  logic [IDX_W-1:0] r_bits_left;    // bits of this copy still to send after o_a
  logic             r_a;
  logic             r_a_vld;
  logic             r_busy;
  logic             r_done;

  state_t           w_state;
  logic [PAT_W-1:0] w_pat;
  logic [REP_W-1:0] w_copies_left;
  logic [GAP_W-1:0] w_gap;
  logic [GAP_W-1:0] w_gap_cnt;
  logic [IDX_W-1:0] w_bits_left;
  logic             w_a;
  logic             w_a_vld;
  logic             w_busy;
  logic             w_done;

  // State and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_pat         <= '0;
      r_copies_left <= '0;
      r_gap         <= '0;
      r_gap_cnt     <= '0;
      r_bits_left   <= '0;
      r_a           <= IDLE_BIT;
      r_a_vld       <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_pat         <= w_pat;
      r_copies_left <= w_copies_left;
      r_gap         <= w_gap;
      r_gap_cnt     <= w_gap_cnt;
      r_bits_left   <= w_bits_left;
      r_a           <= w_a;
      r_a_vld       <= w_a_vld;
      r_busy        <= w_busy;
      r_done        <= w_done;
    end
  end

  // Next state and next registered outputs; idle line levels are the default
  always_comb begin
    w_state       = r_state;
    w_pat         = r_pat;
    w_copies_left = r_copies_left;
    w_gap         = r_gap;
    w_gap_cnt     = r_gap_cnt;
    w_bits_left   = r_bits_left;
    w_a           = IDLE_BIT;
    w_a_vld       = 1'b0;
    w_busy        = 1'b0;
    w_done        = 1'b0;

    case (r_state)
      S_IDLE: begin
        // abort wins over a simultaneous start
        if (i_start && !i_abort) begin
          w_state       = S_SEND;
          w_pat         = i_pat_in;
          w_copies_left = (i_reps == '0) ? '0 : i_reps - REP_W'(1);
          w_gap         = i_gap;
          w_bits_left   = LAST_IDX;
          w_a           = i_pat_in[PAT_W-1];
          w_a_vld       = 1'b1;
          w_busy        = 1'b1;
        end
      end

      S_SEND: begin
        if (i_abort) begin
          w_state = S_IDLE;
        end else if (r_bits_left != '0) begin
          w_bits_left = r_bits_left - IDX_W'(1);
          w_a         = r_pat[r_bits_left - IDX_W'(1)];
          w_a_vld     = 1'b1;
          w_busy      = 1'b1;
        end else if (r_copies_left != '0) begin
          w_busy = 1'b1;
          if (r_gap != '0) begin
            w_state   = S_GAP;
            w_gap_cnt = r_gap - GAP_W'(1);
          end else begin
            // back-to-back copy: next MSB with no bubble
            w_copies_left = r_copies_left - REP_W'(1);
            w_bits_left   = LAST_IDX;
            w_a           = r_pat[PAT_W-1];
            w_a_vld       = 1'b1;
          end
        end else begin
          w_state = S_DONE;
          w_busy  = 1'b1;
          w_done  = 1'b1;
        end
      end

      S_GAP: begin
        if (i_abort) begin
          w_state = S_IDLE;
        end else if (r_gap_cnt != '0) begin
          w_gap_cnt = r_gap_cnt - GAP_W'(1);
          w_busy    = 1'b1;
        end else begin
          w_state       = S_SEND;
          w_copies_left = r_copies_left - REP_W'(1);
          w_bits_left   = LAST_IDX;
          w_a           = r_pat[PAT_W-1];
          w_a_vld       = 1'b1;
          w_busy        = 1'b1;
        end
      end

      S_DONE: begin
        w_state = S_IDLE;
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  assign o_a     = r_a;
  assign o_a_vld = r_a_vld;
  assign o_busy  = r_busy;
  assign o_done  = r_done;

endmodule

// File: tb/tb_fsm_sequence_gen.sv
// Bench for fsm_sequence_gen: a queue model of the expected per-cycle output
// stream, checked every cycle, plus literal expectations per directed scenario.
module tb_fsm_sequence_gen;

  localparam int unsigned PAT_W = 4;
  localparam int unsigned REP_W = 4;
  localparam int unsigned GAP_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [PAT_W-1:0] pat_in;
  logic [REP_W-1:0] reps;
  logic [GAP_W-1:0] gap;
  logic             abort;
  logic             o_a;
  logic             o_a_vld;
  logic             o_busy;
  logic             o_done;

  always #5 clk = ~clk;

  fsm_sequence_gen #(
    .PAT_W(PAT_W), .REP_W(REP_W), .GAP_W(GAP_W), .IDLE_BIT(1'b1)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_pat_in(pat_in),
    .i_reps(reps), .i_gap(gap), .i_abort(abort),
    .o_a(o_a), .o_a_vld(o_a_vld), .o_busy(o_busy), .o_done(o_done)
  );

  // Expected output tuple: {a, a_vld, busy, done}
  typedef struct packed {
    logic a;
    logic vld;
    logic busy;
    logic done;
  } exp_t;

  localparam exp_t IDLE_E = 4'b1000;
  localparam exp_t GAP_E  = 4'b1010;
  localparam exp_t DONE_E = 4'b1011;

  exp_t cur = IDLE_E;
  exp_t pend[$];

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  int          busy_cnt;
  int          done_cnt;
  int          det_cnt;
  logic [31:0] a_log;
  logic [3:0]  hist;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  // Expected stream for one transmission, built from the behavioural rules
  task automatic build(input logic [PAT_W-1:0] p, input int r, input int g);
    int rr;
    rr = (r == 0) ? 1 : r;
    pend.delete();
    for (int c = 0; c < rr; c++) begin
      for (int b = PAT_W - 1; b >= 0; b--) pend.push_back(exp_t'({p[b], 3'b110}));
      if (c < rr - 1)
        for (int k = 0; k < g; k++) pend.push_back(GAP_E);
    end
    pend.push_back(DONE_E);
  endtask

  // Model: advance expected output on every edge from the same inputs the DUT sees
  always @(posedge clk) begin
    if (reset) begin
      cur = IDLE_E;
      pend.delete();
    end else if (!cur.busy) begin
      if (start && !abort) begin
        build(pat_in, int'(reps), int'(gap));
        cur = pend.pop_front();
      end else begin
        cur = IDLE_E;
      end
    end else if (abort && !cur.done) begin
      cur = IDLE_E;
      pend.delete();
    end else if (pend.size() > 0) begin
      cur = pend.pop_front();
    end else begin
      cur = IDLE_E;
    end
  end

  // Compare against the model and gather per-scenario observations
  always @(negedge clk) begin
    if (chk_en) begin
      check("stream", 32'({o_a, o_a_vld, o_busy, o_done}), 32'(cur));
      if (o_busy) begin
        busy_cnt++;
        a_log = {a_log[30:0], o_a};
      end
      if (o_done) done_cnt++;
      hist = {hist[2:0], o_a};
      if (hist == 4'b0110) det_cnt++;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    busy_cnt = 0;
    done_cnt = 0;
    det_cnt  = 0;
    a_log    = '0;
    hist     = 4'b1111;
  endtask

  // One transmission; inputs scrambled right after start to prove latching
  task automatic run(input logic [PAT_W-1:0] p, input int r, input int g, input int n);
    pat_in = p;
    reps   = REP_W'(r);
    gap    = GAP_W'(g);
    start  = 1'b1;
    clear_mon();
    cycle();
    start  = 1'b0;
    pat_in = ~p;
    reps   = '0;
    gap    = '1;
    repeat (n) cycle();
    settle();
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    abort  = 1'b0;
    pat_in = '0;
    reps   = '0;
    gap    = '0;
    clear_mon();
    cycle();
    chk_en = 1'b1;
    cycle();
    reset = 1'b0;
    settle();
    check("rst_a", 32'(o_a), 32'd1);
    check("rst_vld", 32'(o_a_vld), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);

    // single copy 0110
    run(4'b0110, 1, 0, 5);
    check("t1_busy_cycles", 32'(busy_cnt), 32'd5);
    check("t1_a_bits", 32'(a_log[4:0]), 32'(5'b01101));
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
    check("t1_busy_low", 32'(o_busy), 32'd0);

    // three copies with gap of two
    run(4'b0110, 3, 2, 17);
    check("t2_busy_cycles", 32'(busy_cnt), 32'd17);
    check("t2_a_bits", 32'(a_log[16:0]), 32'(17'b01101101101101101));
    check("t2_done_cnt", 32'(done_cnt), 32'd1);

    // four back-to-back copies into a 0110 matcher
    run(4'b0110, 4, 0, 17);
    check("t3_busy_cycles", 32'(busy_cnt), 32'd17);
    check("t3_a_bits", 32'(a_log[16:0]), 32'(17'b01100110011001101));
    check("t3_detect_cnt", 32'(det_cnt), 32'd4);

    // reps=0 behaves as one copy; start held into SEND is ignored
    pat_in = 4'b1010;
    reps   = '0;
    gap    = 4'd3;
    start  = 1'b1;
    clear_mon();
    repeat (3) cycle();
    start = 1'b0;
    repeat (4) cycle();
    settle();
    check("t4_busy_cycles", 32'(busy_cnt), 32'd5);
    check("t4_a_bits", 32'(a_log[4:0]), 32'(5'b10101));
    check("t4_done_cnt", 32'(done_cnt), 32'd1);

    // abort on first bit of the second copy
    pat_in = 4'b0110;
    reps   = 4'd3;
    gap    = 4'd1;
    start  = 1'b1;
    clear_mon();
    cycle();
    start = 1'b0;
    repeat (5) cycle();
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    settle();
    check("t5_busy_cycles", 32'(busy_cnt), 32'd6);
    check("t5_a_bits", 32'(a_log[5:0]), 32'(6'b011010));
    check("t5_no_done", 32'(done_cnt), 32'd0);
    check("t5_busy_low", 32'(o_busy), 32'd0);
    check("t5_a_idle", 32'(o_a), 32'd1);
    run(4'b0110, 1, 0, 5);
    check("t5_restart_busy", 32'(busy_cnt), 32'd5);
    check("t5_restart_done", 32'(done_cnt), 32'd1);

    // reset during GAP, with start in the same cycle
    pat_in = 4'b0110;
    reps   = 4'd2;
    gap    = 4'd3;
    start  = 1'b1;
    clear_mon();
    cycle();
    start = 1'b0;
    repeat (4) cycle();
    settle();
    check("t6_in_gap_vld", 32'(o_a_vld), 32'd0);
    check("t6_in_gap_busy", 32'(o_busy), 32'd1);
    reset = 1'b1;
    start = 1'b1;
    cycle();
    reset = 1'b0;
    start = 1'b0;
    settle();
    check("t6_rst_busy", 32'(o_busy), 32'd0);
    check("t6_rst_a", 32'(o_a), 32'd1);
    check("t6_rst_vld", 32'(o_a_vld), 32'd0);
    repeat (3) cycle();
    settle();
    check("t6_start_ignored", 32'(o_busy), 32'd0);
    check("t6_no_done", 32'(done_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
